// File: rtl/hs_traffic_master_if.sv
// Valid/ready beat bus between the traffic master and its sink.
interface hs_traffic_master_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hs_traffic_master.sv
// Valid/ready traffic source: incrementing wrapping pattern in on/off bursts,
// optional skid-buffer output slice, saturating transfer/stall statistics.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for START_DELAY enabled cycles before the first burst
// ST_ON   | burst window, new beats may be offered (ON_CYCLES long)
// ST_OFF  | gap window, no new beats are loaded (OFF_CYCLES long)
module hs_traffic_master #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned START_VAL   = 2,
    parameter int unsigned END_VAL     = 255,
    parameter int unsigned START_DELAY = 10,
    parameter int unsigned ON_CYCLES   = 5,
    parameter int unsigned OFF_CYCLES  = 5,
    parameter int unsigned OUT_REG     = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     enable_i,
    hs_traffic_master_if.master      bus,
    output logic [CNT_W-1:0]         xfer_cnt_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic                     wrap_o
);

    localparam logic [DATA_W-1:0] START_D = DATA_W'(START_VAL);
    localparam logic [DATA_W-1:0] END_D   = DATA_W'(END_VAL);
    localparam logic [DATA_W-1:0] ONE_D   = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  MAX_C   = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    state_t            state_q;
    logic [31:0]       tmr_q;

    logic              src_valid_q;
    logic [DATA_W-1:0] src_data_q;
    logic [DATA_W-1:0] pat_q;
    logic              src_acc;

    logic [CNT_W-1:0]  xfer_q;
    logic [CNT_W-1:0]  stall_q;
    logic              wrap_q;

    // Window FSM; the timer is a down-counter that fires on terminal count 1.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= 32'(START_DELAY);
        end else if (!enable_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= 32'(START_DELAY);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tmr_q == 32'd1) begin
                        state_q <= ST_ON;
                        tmr_q   <= 32'(ON_CYCLES);
                    end else begin
                        tmr_q <= tmr_q - 32'd1;
                    end
                end
                ST_ON: begin
                    if (tmr_q == 32'd1) begin
                        state_q <= ST_OFF;
                        tmr_q   <= 32'(OFF_CYCLES);
                    end else begin
                        tmr_q <= tmr_q - 32'd1;
                    end
                end
                ST_OFF: begin
                    if (tmr_q == 32'd1) begin
                        state_q <= ST_ON;
                        tmr_q   <= 32'(ON_CYCLES);
                    end else begin
                        tmr_q <= tmr_q - 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= 32'(START_DELAY);
                end
            endcase
        end
    end

    // Source beat: load the next pattern value only when the slot is free,
    // so a pending beat is never altered. pat_q holds the value to offer next
    // and steps once per loaded beat, which equals once per accepted beat.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            src_valid_q <= 1'b0;
            src_data_q  <= START_D;
            pat_q       <= START_D;
        end else if ((state_q == ST_ON) && (!src_valid_q || src_acc)) begin
            src_valid_q <= 1'b1;
            src_data_q  <= pat_q;
            pat_q       <= (pat_q == END_D) ? START_D : pat_q + ONE_D;
        end else if (src_acc) begin
            src_valid_q <= 1'b0;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            assign bus.valid = src_valid_q;
            assign bus.data  = src_data_q;
            assign src_acc   = src_valid_q & bus.ready;
        end else begin : g_skid
            logic              out_valid_q;
            logic [DATA_W-1:0] out_data_q;
            logic              skid_valid_q;
            logic [DATA_W-1:0] skid_data_q;
            logic              rdy_int_q;
            logic              out_fire;

            assign out_fire  = out_valid_q & bus.ready;
            // Source side only sees the registered ready, cutting the ready path.
            assign src_acc   = src_valid_q & rdy_int_q;
            assign bus.valid = out_valid_q;
            assign bus.data  = out_data_q;

            // Two-entry skid slice; rdy_int_q tracks "skid entry empty".
            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset) begin
                    out_valid_q  <= 1'b0;
                    out_data_q   <= START_D;
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                    rdy_int_q    <= 1'b0;
                end else if (out_fire || !out_valid_q) begin
                    rdy_int_q <= 1'b1;
                    if (skid_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_data_q   <= skid_data_q;
                        skid_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= src_acc;
                        if (src_acc) begin
                            out_data_q <= src_data_q;
                        end
                    end
                end else if (src_acc) begin
                    skid_valid_q <= 1'b1;
                    skid_data_q  <= src_data_q;
                    rdy_int_q    <= 1'b0;
                end
            end
        end
    endgenerate

    // Output-side statistics (saturating) and the registered wrap pulse.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            xfer_q  <= '0;
            stall_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            if (bus.valid && bus.ready && (xfer_q != MAX_C)) begin
                xfer_q <= xfer_q + ONE_C;
            end
            if (bus.valid && !bus.ready && (stall_q != MAX_C)) begin
                stall_q <= stall_q + ONE_C;
            end
            wrap_q <= bus.valid && bus.ready && (bus.data == END_D);
        end
    end

    assign xfer_cnt_o  = xfer_q;
    assign stall_cnt_o = stall_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_hs_traffic_master.sv
// Directed bench for hs_traffic_master: four instances cover the direct
// output, skid output, short wrapping pattern and narrow counters.
module tb_hs_traffic_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;
    logic en_a, en_b, en_c, en_d;

    hs_traffic_master_if #(.DATA_W(8)) bus_a ();
    hs_traffic_master_if #(.DATA_W(8)) bus_b ();
    hs_traffic_master_if #(.DATA_W(8)) bus_c ();
    hs_traffic_master_if #(.DATA_W(8)) bus_d ();

    logic [15:0] xfer_a, stall_a, xfer_b, stall_b, xfer_c, stall_c;
    logic [3:0]  xfer_d, stall_d;
    logic        wrap_a, wrap_b, wrap_c, wrap_d;

    hs_traffic_master #(.OUT_REG(0)) u_a (
        .sys_clk(clk), .reset(rst_a), .enable_i(en_a), .bus(bus_a),
        .xfer_cnt_o(xfer_a), .stall_cnt_o(stall_a), .wrap_o(wrap_a));

    hs_traffic_master #(.OUT_REG(1)) u_b (
        .sys_clk(clk), .reset(rst_b), .enable_i(en_b), .bus(bus_b),
        .xfer_cnt_o(xfer_b), .stall_cnt_o(stall_b), .wrap_o(wrap_b));

    hs_traffic_master #(.START_VAL(250), .END_VAL(253), .OUT_REG(0)) u_c (
        .sys_clk(clk), .reset(rst_c), .enable_i(en_c), .bus(bus_c),
        .xfer_cnt_o(xfer_c), .stall_cnt_o(stall_c), .wrap_o(wrap_c));

    hs_traffic_master #(.CNT_W(4), .OUT_REG(0)) u_d (
        .sys_clk(clk), .reset(rst_d), .enable_i(en_d), .bus(bus_d),
        .xfer_cnt_o(xfer_d), .stall_cnt_o(stall_d), .wrap_o(wrap_d));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int          nxt;
    int          acc;
    int          stl;
    logic        pend;
    logic [7:0]  pdat;
    logic        exp_v;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        en_a = 1'b1;  en_b = 1'b1;  en_c = 1'b1;  en_d = 1'b1;
        bus_a.ready = 1'b1; bus_b.ready = 1'b1; bus_c.ready = 1'b1; bus_d.ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(bus_a.valid), 32'd0);
        chk("rst_data",  32'(bus_a.data),  32'd2);
        chk("rst_xfer",  32'(xfer_a),      32'd0);
        chk("rst_stall", 32'(stall_a),     32'd0);
        chk("rst_wrap",  32'(wrap_a),      32'd0);

        // Two bursts with ready held high
        rst_a = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            exp_v = (k >= 11 && k <= 15) || (k >= 21 && k <= 25);
            chk("t1_valid", 32'(bus_a.valid), 32'(exp_v));
            if (exp_v) chk("t1_data", 32'(bus_a.data), (k <= 15) ? k - 9 : k - 14);
        end
        chk("t1_xfer",  32'(xfer_a),  32'd10);
        chk("t1_stall", 32'(stall_a), 32'd0);

        // Backpressure on the first beat
        rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_pre_valid", 32'(bus_a.valid), 32'd0);
        bus_a.ready = 1'b0;
        for (int k = 11; k <= 14; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(bus_a.valid), 32'd1);
            chk("t2_hold_data",  32'(bus_a.data),  32'd2);
            chk("t2_stall_run",  32'(stall_a),     k - 11);
        end
        bus_a.ready = 1'b1;
        nxt = 2;
        for (int k = 14; k < 30; k++) begin
            if (bus_a.valid) begin
                chk("t2_seq", 32'(bus_a.data), nxt);
                nxt++;
            end
            @(negedge clk);
        end
        chk("t2_xfer",  32'(xfer_a),  32'd7);
        chk("t2_stall", 32'(stall_a), 32'd3);

        // Reset mid-burst with a pending beat
        rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_pend_data", 32'(bus_a.data), 32'd3);
        chk("t5_pend_xfer", 32'(xfer_a),     32'd1);
        bus_a.ready = 1'b0;
        @(negedge clk);
        chk("t5_pend_stall", 32'(stall_a), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus_a.valid), 32'd0);
        chk("t5_rst_data",  32'(bus_a.data),  32'd2);
        chk("t5_rst_xfer",  32'(xfer_a),      32'd0);
        chk("t5_rst_stall", 32'(stall_a),     32'd0);
        @(negedge clk);
        rst_a = 1'b0; bus_a.ready = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("t5_restart_valid", 32'(bus_a.valid), 32'(k == 11));
        end
        chk("t5_restart_data", 32'(bus_a.data), 32'd2);

        // Enable dropped with a pending beat
        rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
        repeat (12) @(negedge clk);
        bus_a.ready = 1'b0; en_a = 1'b0;
        for (int k = 13; k <= 14; k++) begin
            @(negedge clk);
            chk("t6_pend_valid", 32'(bus_a.valid), 32'd1);
            chk("t6_pend_data",  32'(bus_a.data),  32'd3);
        end
        bus_a.ready = 1'b1;
        @(negedge clk);
        chk("t6_drain_valid", 32'(bus_a.valid), 32'd0);
        chk("t6_drain_xfer",  32'(xfer_a),      32'd2);
        repeat (3) @(negedge clk);
        chk("t6_off_valid", 32'(bus_a.valid), 32'd0);
        en_a = 1'b1;
        for (int k = 19; k <= 29; k++) begin
            @(negedge clk);
            chk("t6_reen_valid", 32'(bus_a.valid), 32'(k == 29));
        end
        chk("t6_reen_data", 32'(bus_a.data), 32'd4);

        // Short wrapping pattern 250..253
        rst_c = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            exp_v = (k >= 11 && k <= 15);
            chk("t3_valid", 32'(bus_c.valid), 32'(exp_v));
            if (exp_v) chk("t3_data", 32'(bus_c.data), (k == 15) ? 250 : 239 + k);
            chk("t3_wrap", 32'(wrap_c), 32'(k == 15));
        end
        chk("t3_xfer", 32'(xfer_c), 32'd5);

        // Skid-buffer output: latency, no bubbles, then random ready
        rst_b = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_v = (k >= 12 && k <= 16);
            chk("t4_valid", 32'(bus_b.valid), 32'(exp_v));
            if (exp_v) chk("t4_data", 32'(bus_b.data), k - 10);
        end
        nxt = 7; acc = 5; stl = 0;
        for (int i = 0; i < 500; i++) begin
            bus_b.ready = 1'($urandom_range(0, 1));
            if (bus_b.valid && bus_b.ready) begin
                chk("t4_seq", 32'(bus_b.data), nxt);
                nxt = (nxt == 255) ? 2 : nxt + 1;
                acc++;
            end
            pend = bus_b.valid && !bus_b.ready;
            pdat = bus_b.data;
            if (pend) stl++;
            @(negedge clk);
            if (pend) begin
                chk("t4_hold_valid", 32'(bus_b.valid), 32'd1);
                chk("t4_hold_data",  32'(bus_b.data),  32'(pdat));
            end
        end
        chk("t4_xfer",  32'(xfer_b),  acc);
        chk("t4_stall", 32'(stall_b), stl);

        // Narrow counters saturate
        rst_d = 1'b0;
        repeat (25) @(negedge clk);
        chk("t6b_stall_14", 32'(stall_d), 32'd14);
        @(negedge clk);
        chk("t6b_stall_15", 32'(stall_d), 32'd15);
        repeat (10) @(negedge clk);
        chk("t6b_stall_sat", 32'(stall_d),     32'd15);
        chk("t6b_valid",     32'(bus_d.valid), 32'd1);
        chk("t6b_data",      32'(bus_d.data),  32'd2);
        chk("t6b_xfer",      32'(xfer_d),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_traffic_master.md
Name: hs_traffic_master

Overview:
Parametrised valid/ready traffic source for handshake and backpressure testing. It emits an incrementing, wrapping data pattern in programmable on/off bursts and obeys the rule that an offered beat stays valid and stable until it is accepted. An optional full-throughput output register slice is included. Transfer and stall statistics are kept for the bench and for debug.

Parameters:
DATA_W, 8, data width in bits.
START_VAL, 2, first pattern value and the value used after a wrap.
END_VAL, 255, last pattern value before wrap. Legal range: START_VAL <= END_VAL < 2^DATA_W.
START_DELAY, 10, enabled cycles spent in IDLE before the first burst. Must be >= 1.
ON_CYCLES, 5, length in cycles of each burst window. Must be >= 1.
OFF_CYCLES, 5, length in cycles of each gap window. Must be >= 1.
OUT_REG, 1, 1 = skid-buffer register slice on the outputs; 0 = outputs driven directly from the source register.
CNT_W, 16, width of the statistics counters.

Ports:
sys_clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  permits new bursts
ready  in  1  downstream accepts the beat
valid  out  1  beat offered
data  out  DATA_W  beat payload
xfer_cnt  out  CNT_W  accepted beats, saturating
stall_cnt  out  CNT_W  cycles with valid=1 and ready=0, saturating
wrap  out  1  one-cycle pulse, the cycle after END_VAL is accepted at the output

Behaviour:
- Reset: all registers clear immediately. Outputs during reset: valid=0, data=START_VAL, xfer_cnt=0, stall_cnt=0, wrap=0. FSM=IDLE. Any pending or buffered beat is discarded.
- Gap FSM (IDLE, ON, OFF):
  - IDLE: counts edges while enable=1; enters ON on the edge where the count reaches START_DELAY.
  - ON: lasts exactly ON_CYCLES cycles, then goes to OFF.
  - OFF: lasts exactly OFF_CYCLES cycles, then goes to ON.
  - enable=0 in any state: go to IDLE and clear the delay count.
- Source stage (src_valid, src_data):
  - On an edge where FSM==ON and (src_valid==0 or the source beat is accepted), load the next pattern value and set src_valid=1.
  - On an edge where FSM!=ON and the source beat is accepted, clear src_valid.
  - A pending beat is never dropped or changed, whatever FSM, enable or window boundaries do.
- Pattern:
  - Advances only when the source beat is accepted: next = (cur==END_VAL) ? START_VAL : cur+1, in DATA_W bits.
  - The first beat after reset is START_VAL.
- OUT_REG=0:
  - valid/data = src_valid/src_data; source accepted = valid & ready.
  - With ready=1: valid rises on edge START_DELAY+1 after reset release (enable=1 throughout) and is high exactly ON_CYCLES cycles per burst.
- OUT_REG=1:
  - 2-entry skid buffer between source and outputs; source accepted = src_valid & internal ready, where internal ready is a registered signal.
  - Adds exactly 1 cycle of latency; no bubbles under continuous ready.
  - No combinational path from ready to the source stage.
  - Accepted output sequence is identical to OUT_REG=0 for any ready pattern.
- Output rules: while valid=1 and ready=0, data is held; valid never deasserts without a handshake.
- Statistics and wrap:
  - xfer_cnt increments on each output valid&ready; stall_cnt increments on each output valid&!ready.
  - Both counters saturate at 2^CNT_W-1.
  - wrap is registered: asserted the cycle after an output handshake whose data==END_VAL.
- Simultaneous events:
  - A handshake in the last ON cycle still loads a new beat.
  - A handshake in the same cycle the FSM leaves ON clears src_valid.
  - Reset overrides everything.

Test Plan:
1. Defaults, OUT_REG=0, enable=1, ready=1 -> valid high edges 11-15 with data 2,3,4,5,6; low for 5 cycles; next burst 7..11; xfer_cnt=10, stall_cnt=0 after two bursts.
2. OUT_REG=0, ready=0 for 3 cycles from first valid -> data=2 stable and valid high throughout; stall_cnt=3; accepted sequence contiguous 2,3,4... with no loss or duplicate.
3. START_VAL=250, END_VAL=253, ready=1 -> accepted 250,251,252,253,250; exactly one wrap pulse, in the cycle after 253 is accepted.
4. OUT_REG=1, random ready (50%) for 500 cycles -> same accepted sequence as the OUT_REG=0 run; no gaps inside bursts when ready=1; first valid on edge 12.
5. Reset asserted mid-burst with a beat pending (ready=0) -> valid=0 and counters=0 immediately; after release, first beat is 2 on edge 11.
6. enable dropped mid-burst with a beat pending and ready=0; then ready=1 -> pending beat accepted; valid then stays 0 until enable is high again for 10 cycles. CNT_W=4 run -> stall_cnt saturates at 15.
